// File: rtl/interval_timer_if.sv
// Control/status bundle between the microcode strobes, the datapath and the interval timer.
interface interval_timer_if #(
    parameter int IVL_WIDTH = 12
);
    logic                 clken;
    logic                 timerCLRCNT;
    logic                 timerWRIVL;
    logic                 timerCLRFLG;
    logic [0:35]          dp;
    logic [18:35]         timerCOUNT;
    logic [IVL_WIDTH-1:0] timerIVL;
    logic                 timerFLAG;
    logic                 timerWRAP;

    modport master (
        output clken, timerCLRCNT, timerWRIVL, timerCLRFLG, dp,
        input  timerCOUNT, timerIVL, timerFLAG, timerWRAP
    );

    modport slave (
        input  clken, timerCLRCNT, timerWRIVL, timerCLRFLG, dp,
        output timerCOUNT, timerIVL, timerFLAG, timerWRAP
    );
endinterface

// File: rtl/interval_timer.sv
// Interval timer: prescaled 18-bit free-running count for the DBM, plus a sticky
// interval interrupt flag for the APR flag register.
module interval_timer #(
    parameter int TICK_DIV  = 6,
    parameter int IVL_WIDTH = 12
) (
    input  logic            clk,
    input  logic            rst,
    interval_timer_if.slave bus
);
    localparam logic [7:0]  PRESC_LAST = 8'(TICK_DIV - 1);
    localparam logic [17:0] COUNT_MAX  = 18'h3FFFF;

    logic [7:0]           presc_r;
    logic [7:0]           presc_nxt_s;
    logic [17:0]          count_r;
    logic [17:0]          count_nxt_s;
    logic [IVL_WIDTH-1:0] ivl_r;
    logic [IVL_WIDTH-1:0] ivl_nxt_s;
    logic [IVL_WIDTH-1:0] ivl_cnt_r;
    logic [IVL_WIDTH-1:0] ivl_cnt_nxt_s;
    logic                 flag_r;
    logic                 flag_nxt_s;
    logic                 wrap_r;
    logic                 wrap_nxt_s;
    logic                 tick_s;
    logic                 clr_cnt_s;
    logic                 wr_ivl_s;
    logic                 clr_flg_s;
    logic                 expire_s;
    logic                 unused_dp_s;

    assign unused_dp_s = ^bus.dp[0:35-IVL_WIDTH];

    // Strobe qualification, tick decode and interval expiry detection.
    always_comb begin
        tick_s    = (presc_r == PRESC_LAST);
        clr_cnt_s = bus.clken & bus.timerCLRCNT;
        wr_ivl_s  = bus.clken & bus.timerWRIVL;
        clr_flg_s = bus.clken & bus.timerCLRFLG;
        // A write in the same clk swallows the tick for the interval logic only.
        expire_s  = tick_s & ~wr_ivl_s & (ivl_r != {IVL_WIDTH{1'b0}})
                  & (ivl_cnt_r == (ivl_r - IVL_WIDTH'(1)));
    end

    // Prescaler and free-running count; a clear beats a coincident tick and never wraps.
    always_comb begin
        presc_nxt_s = presc_r;
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
        if (clr_cnt_s) begin
            presc_nxt_s = 8'd0;
            count_nxt_s = 18'd0;
        end else if (tick_s) begin
            presc_nxt_s = 8'd0;
            count_nxt_s = count_r + 18'd1;
            wrap_nxt_s  = (count_r == COUNT_MAX);
        end else begin
            presc_nxt_s = presc_r + 8'd1;
        end
    end

    // Interval register and interval counter.
    always_comb begin
        ivl_nxt_s     = ivl_r;
        ivl_cnt_nxt_s = ivl_cnt_r;
        if (wr_ivl_s) begin
            ivl_nxt_s     = bus.dp[36-IVL_WIDTH:35];
            ivl_cnt_nxt_s = {IVL_WIDTH{1'b0}};
        end else if (ivl_r == {IVL_WIDTH{1'b0}}) begin
            ivl_cnt_nxt_s = {IVL_WIDTH{1'b0}};
        end else if (expire_s) begin
            ivl_cnt_nxt_s = {IVL_WIDTH{1'b0}};
        end else if (tick_s) begin
            ivl_cnt_nxt_s = ivl_cnt_r + IVL_WIDTH'(1);
        end else begin
            ivl_cnt_nxt_s = ivl_cnt_r;
        end
    end

    // Sticky flag: a new expiry wins over a simultaneous clear.
    always_comb begin
        flag_nxt_s = flag_r;
        if (expire_s) begin
            flag_nxt_s = 1'b1;
        end else if (clr_flg_s) begin
            flag_nxt_s = 1'b0;
        end else begin
            flag_nxt_s = flag_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_r   <= 8'd0;
            count_r   <= 18'd0;
            ivl_r     <= {IVL_WIDTH{1'b0}};
            ivl_cnt_r <= {IVL_WIDTH{1'b0}};
            flag_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            presc_r   <= presc_nxt_s;
            count_r   <= count_nxt_s;
            ivl_r     <= ivl_nxt_s;
            ivl_cnt_r <= ivl_cnt_nxt_s;
            flag_r    <= flag_nxt_s;
            wrap_r    <= wrap_nxt_s;
        end
    end

    assign bus.timerCOUNT = count_r;
    assign bus.timerIVL   = ivl_r;
    assign bus.timerFLAG  = flag_r;
    assign bus.timerWRAP  = wrap_r;
endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: directed scenarios plus random strobes, checked against an
// arithmetic model (elapsed-cycle phase, ticks since the interval was armed).
module tb_interval_timer;
    localparam int TICK_DIV  = 6;
    localparam int IVL_WIDTH = 12;
    localparam int COUNT_MOD = 262144;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    int   m_phase, m_count, m_ivl, m_since;
    bit   m_flag, m_wrap;

    interval_timer_if #(.IVL_WIDTH(IVL_WIDTH)) tif ();

    interval_timer #(.TICK_DIV(TICK_DIV), .IVL_WIDTH(IVL_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit next_tick();
        return (m_phase % TICK_DIV) == (TICK_DIV - 1);
    endfunction

    function automatic bit next_expires();
        return next_tick() && (m_ivl != 0) && (((m_since + 1) % m_ivl) == 0);
    endfunction

    // One clk: drive inputs, advance the model, then compare all outputs after the edge.
    task automatic step(input bit r, input bit ce, input bit cc, input bit wi,
                        input bit cf, input logic [35:0] dv);
        bit tick, clr, wr, cfl, expire;
        rst             = r;
        tif.clken       = ce;
        tif.timerCLRCNT = cc;
        tif.timerWRIVL  = wi;
        tif.timerCLRFLG = cf;
        tif.dp          = dv;
        if (!r) begin
            m_phase = 0; m_count = 0; m_ivl = 0; m_since = 0; m_flag = 0; m_wrap = 0;
        end else begin
            tick   = next_tick();
            clr    = ce & cc;
            wr     = ce & wi;
            cfl    = ce & cf;
            expire = 1'b0;
            if (tick && !wr && m_ivl != 0) begin
                m_since++;
                expire = (m_since % m_ivl) == 0;
            end
            if (wr) begin
                m_ivl   = int'(dv % 36'd4096);
                m_since = 0;
            end
            m_wrap = tick && !clr && (m_count == COUNT_MOD - 1);
            if (clr) begin
                m_count = 0;
                m_phase = 0;
            end else begin
                if (tick) m_count = (m_count + 1) % COUNT_MOD;
                m_phase++;
            end
            if (expire) m_flag = 1'b1;
            else if (cfl) m_flag = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("count", 36'(tif.timerCOUNT), 36'(m_count));
        chk("ivl",   36'(tif.timerIVL),   36'(m_ivl));
        chk("flag",  36'(tif.timerFLAG),  36'(m_flag));
        chk("wrap",  36'(tif.timerWRAP),  36'(m_wrap));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 36'd0);
    endtask

    initial begin
        bit   done;
        int   wraps;
        logic [35:0] dv;

        // Reset state, then 60 free-running clks.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'd0);
        chk("rst_count", 36'(tif.timerCOUNT), 36'd0);
        idle(60);
        chk("free60_count", 36'(tif.timerCOUNT), 36'd10);
        chk("free60_flag", 36'(tif.timerFLAG), 36'd0);

        // Interval 3 over 18 ticks, clear, then 3 more ticks.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 36'hABC_DEF_003);
        chk("ivl_readback", 36'(tif.timerIVL), 36'd3);
        idle(18 * TICK_DIV);
        chk("ivl3_flag", 36'(tif.timerFLAG), 36'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 36'd0);
        chk("flag_cleared", 36'(tif.timerFLAG), 36'd0);
        idle(3 * TICK_DIV);
        chk("ivl3_reflag", 36'(tif.timerFLAG), 36'd1);

        // Clear coincident with expiry: set wins.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 36'd3);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (next_expires()) begin
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 36'd0);
                chk("set_wins", 36'(tif.timerFLAG), 36'd1);
                done = 1'b1;
            end else begin
                idle(1);
            end
        end
        chk("set_wins_reached", 36'(done), 36'd1);

        // Interval 5 then 0: disabled, no flag.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 36'd5);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 36'd0);
        idle(20 * TICK_DIV);
        chk("ivl0_flag", 36'(tif.timerFLAG), 36'd0);

        // Wrap from 0x3FFFE.
        force dut.count_r = 18'h3FFFE;
        #1;
        release dut.count_r;
        m_count = 'h3FFFE;
        wraps = 0;
        for (int i = 0; i < 3 * TICK_DIV; i++) begin
            idle(1);
            if (tif.timerWRAP === 1'b1) wraps++;
        end
        chk("wrap_pulses", 36'(wraps), 36'd1);

        // Clear coincident with a tick at 0x3FFFF: zero, and no wrap.
        force dut.count_r = 18'h3FFFF;
        #1;
        release dut.count_r;
        m_count = 'h3FFFF;
        done = 1'b0;
        for (int i = 0; i < 2 * TICK_DIV && !done; i++) begin
            if (next_tick()) begin
                step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 36'd0);
                chk("clr_tick_count", 36'(tif.timerCOUNT), 36'd0);
                chk("clr_tick_wrap", 36'(tif.timerWRAP), 36'd0);
                done = 1'b1;
            end else begin
                idle(1);
            end
        end
        chk("clr_tick_reached", 36'(done), 36'd1);
        idle(2);

        // Strobes with clken=0 are ignored.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 36'd2);
        idle(2 * TICK_DIV);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 36'd7);
        chk("gated_ivl", 36'(tif.timerIVL), 36'd2);

        // Reset mid-count with interval 7 and flag set.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 36'd7);
        idle(8 * TICK_DIV);
        chk("pre_rst_flag", 36'(tif.timerFLAG), 36'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 36'd9);
        chk("rst_mid_count", 36'(tif.timerCOUNT), 36'd0);
        chk("rst_mid_ivl", 36'(tif.timerIVL), 36'd0);
        chk("rst_mid_flag", 36'(tif.timerFLAG), 36'd0);
        idle(2 * TICK_DIV);
        chk("resume_count", 36'(tif.timerCOUNT), 36'd2);

        // Random strobes, intervals and occasional resets.
        for (int i = 0; i < 400; i++) begin
            dv = {24'($urandom), 12'($urandom_range(0, 5))};
            step(($urandom % 64) != 0, 1'($urandom), ($urandom % 16) == 0,
                 ($urandom % 8) == 0, ($urandom % 4) == 0, dv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Interval timer that produces the 18-bit free-running timer count consumed by the DBM bus mux on its EXPTIME selection (timerCOUNT[18:35]).
- Also generates the interval-timer interrupt flag that feeds the APR flag register.
- Sits beside the APR block and is loaded from the datapath by microcode strobes.

Parameters:
- TICK_DIV, 6, number of clk cycles per timer tick (prescaler modulus); legal range 1..255.
- IVL_WIDTH, 12, width of the interval register and interval counter.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, synchronous active-low reset; rst==0 at a rising edge resets all state.
- clken, input, 1, CPU clock enable; the microcode strobes below act only when clken==1. The prescaler runs regardless of clken.
- timerCLRCNT, input, 1, microcode strobe: clear the 18-bit count and the prescaler.
- timerWRIVL, input, 1, microcode strobe: load the interval register from dp[24:35] (low IVL_WIDTH bits of dp).
- timerCLRFLG, input, 1, microcode strobe: clear the interrupt flag.
- dp, input, 36 [0:35], datapath; only dp[36-IVL_WIDTH:35] is used.
- timerCOUNT, output, 18 [18:35], free-running tick count to the DBM.
- timerIVL, output, IVL_WIDTH, current interval register value, for readback.
- timerFLAG, output, 1, interval interrupt flag (sticky).
- timerWRAP, output, 1, one-clk pulse when timerCOUNT wraps from 0x3FFFF to 0.

Behaviour:
- Reset (rst==0): prescaler=0, timerCOUNT=0, interval counter=0, timerIVL=0, timerFLAG=0, timerWRAP=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 on every clk, then wraps to 0.
  - tick=1 for exactly the one clk in which the prescaler equals TICK_DIV-1.
  - TICK_DIV=1 makes tick=1 on every clk.
- Count:
  - On tick, timerCOUNT <= timerCOUNT+1, modulo 2^18.
  - On wrap (0x3FFFF->0), timerWRAP=1 in the following clk only (registered; 1-clk latency); otherwise 0.
- Clear count:
  - timerCLRCNT&clken sets timerCOUNT=0 and prescaler=0 next clk.
  - Clear has priority over a simultaneous tick.
  - No timerWRAP is generated by a clear.
- Interval counter:
  - Advances on tick only while timerIVL!=0.
  - When it equals timerIVL-1 at a tick: reset it to 0 and set timerFLAG=1. Result: exactly one flag set per timerIVL ticks.
  - timerIVL==0 disables the interval logic: the counter is held at 0 and the flag is never set by the interval logic.
- Write interval:
  - timerWRIVL&clken loads timerIVL and clears the interval counter in the same edge.
  - A tick in the same clk is discarded for the interval counter only; timerCOUNT still advances.
  - The flag is not affected by the write.
- Flag:
  - Sticky until timerCLRFLG&clken.
  - If clear and a new interval expiry occur in the same clk, set wins (timerFLAG=1).
- Latency and gating:
  - All outputs are registered; strobe effects are visible in the clk after the strobe edge.
  - Strobes with clken==0 are ignored.
  - Multiple strobes in one clk are each applied independently, with the priorities above.
- Reset mid-operation overrides all strobes and ticks in that clk.

Test Plan:
- Reset then run 60 clk with TICK_DIV=6 and no strobes -> timerCOUNT==10, timerFLAG==0, timerWRAP never asserted.
- Write dp[24:35]=3 with clken=1, run 18 ticks -> timerFLAG sets at the 3rd tick after the write. Then clear the flag and run 3 more ticks -> flag sets again. timerIVL reads 3.
- Write interval 3, run 2 ticks, assert timerCLRFLG in the same clk as the 3rd tick's expiry -> timerFLAG==1 (set wins).
- Write interval 5 then 0 -> no flag after 20 ticks; interval counter held at 0.
- Drive timerCOUNT to 0x3FFFE via ticks (force or TICK_DIV=1), run 2 clk -> timerCOUNT==0, timerWRAP high for exactly 1 clk. Assert timerCLRCNT coincident with a tick -> timerCOUNT==0 next clk, no wrap pulse.
- Assert all strobes with clken=0 -> no state change. Assert rst=0 for one clk mid-count with interval 7 and flag set -> all outputs 0 next clk, counting resumes from 0.
